// File: rtl/sn_reg_file.sv
// Bus-side register file and timebase for the SN76489-compatible PSG core.
// Decodes latch/data host bytes into tone, attenuation and noise registers, and runs READY and tone_clk.
module sn_reg_file #(
   parameter int PRESCALE    = 16,
   parameter int BUSY_CYCLES = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_n,
   input  logic [7:0] data,
   output logic       ready,
   output logic       tone_clk,
   output logic [9:0] freq0,
   output logic [9:0] freq1,
   output logic [9:0] freq2,
   output logic [3:0] att0,
   output logic [3:0] att1,
   output logic [3:0] att2,
   output logic [3:0] att3,
   output logic [2:0] noise_ctrl,
   output logic       noise_rst
);

   localparam int PW = $clog2(PRESCALE);
   localparam int BW = $clog2(BUSY_CYCLES + 1);

   logic [PW-1:0] pre_cnt;
   logic [BW-1:0] busy_cnt;
   logic          wr_n_q;
   logic [2:0]    ptr;
   logic          accept;
   logic          is_latch;
   logic [2:0]    tgt;

   // Free-running prescaler; the enable is decoded straight from the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt <= '0;
      end else if (pre_cnt == PW'(PRESCALE - 1)) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   assign tone_clk = (pre_cnt == PW'(PRESCALE - 1));

   // A write is a falling edge of wr_n seen while idle.
   assign accept   = !wr_n && wr_n_q && ready;
   assign is_latch = data[7];
   assign tgt      = is_latch ? data[6:4] : ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_n_q   <= 1'b1;
         ready    <= 1'b1;
         busy_cnt <= '0;
      end else begin
         wr_n_q <= wr_n;
         if (accept) begin
            ready    <= 1'b0;
            busy_cnt <= BW'(BUSY_CYCLES);
         end else if (busy_cnt != '0) begin
            busy_cnt <= busy_cnt - 1'b1;
            ready    <= (busy_cnt == BW'(1));
         end
      end
   end

   // Target is {channel, type}: type 1 selects attenuation, channel 3 type 0 is noise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr        <= 3'b000;
         freq0      <= '0;
         freq1      <= '0;
         freq2      <= '0;
         att0       <= 4'hF;
         att1       <= 4'hF;
         att2       <= 4'hF;
         att3       <= 4'hF;
         noise_ctrl <= '0;
         noise_rst  <= 1'b0;
      end else begin
         noise_rst <= 1'b0;
         if (accept) begin
            if (is_latch) begin
               ptr <= data[6:4];
            end
            if (tgt[0]) begin
               case (tgt[2:1])
                  2'd0: att0 <= data[3:0];
                  2'd1: att1 <= data[3:0];
                  2'd2: att2 <= data[3:0];
                  2'd3: att3 <= data[3:0];
               endcase
            end else begin
               case (tgt[2:1])
                  2'd0: if (is_latch) freq0[3:0] <= data[3:0]; else freq0[9:4] <= data[5:0];
                  2'd1: if (is_latch) freq1[3:0] <= data[3:0]; else freq1[9:4] <= data[5:0];
                  2'd2: if (is_latch) freq2[3:0] <= data[3:0]; else freq2[9:4] <= data[5:0];
                  2'd3: begin
                     noise_ctrl <= data[2:0];
                     noise_rst  <= 1'b1;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: doc/sn_reg_file.md
Name: sn_reg_file

Overview:
- Bus-side register file and timebase for the SN76489-compatible PSG core.
- Decodes the chip's byte-wide write protocol (latch/data bytes) into three 10-bit tone periods, four 4-bit attenuations and the 3-bit noise control.
- Drives the READY handshake back to the host.
- Generates the prescaled tone_clk enable pulse that clocks the tone and noise channel counters directly downstream.

Parameters:
- PRESCALE, 16, clk cycles per tone_clk pulse (>=2).
- BUSY_CYCLES, 32, clk cycles READY stays low after an accepted write (>=1).

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- wr_n  input  1  host write strobe, active low, synchronous to clk
- data  input  8  host write byte, valid while wr_n low
- ready  output  1  high = core can accept a write
- tone_clk  output  1  one-clk-wide enable pulse every PRESCALE cycles
- freq0, freq1, freq2  output  10 each  tone channel 0/1/2 period
- att0, att1, att2, att3  output  4 each  attenuation for tone 0-2 and noise; 0 = loudest, F = off
- noise_ctrl  output  3  noise control: bit2 = white/periodic, bits1:0 = rate select
- noise_rst  output  1  one-clk pulse on every write to the noise control register

Behaviour:
- Reset (async assert, outputs valid immediately):
  - freq0-2 = 0, att0-3 = 4'hF, noise_ctrl = 0, noise_rst = 0.
  - ready = 1, tone_clk = 0, prescale counter = 0, busy counter = 0.
  - Latched-register pointer = channel 0 tone; wr_n history flop = 1.
  - Deassertion takes effect on the next clk edge.
- Write detection:
  - wr_n is registered each cycle.
  - A write is accepted in the cycle where wr_n = 0, the registered wr_n = 1 (falling edge), and ready = 1.
  - data is captured in that same cycle.
  - Falling edges while ready = 0 are ignored entirely: no register change, no pointer change.
  - Holding wr_n low produces a single write.
- Byte decode (bit7 = MSB):
  - data[7] = 1, latch byte:
    - pointer <= {data[6:5] channel, data[4] type}; type 0 = tone/noise, 1 = attenuation.
    - Tone ch0-2: freq[3:0] <= data[3:0], freq[9:4] unchanged.
    - Attenuation: attN <= data[3:0].
    - Channel 3, type 0: noise_ctrl <= data[2:0], data[3] ignored.
  - data[7] = 0, data byte, goes to the pointed register; pointer unchanged:
    - Tone: freq[9:4] <= data[5:0], freq[3:0] unchanged.
    - Attenuation: attN <= data[3:0].
    - Noise: noise_ctrl <= data[2:0]; data[6] ignored in all cases.
  - Data byte before any latch byte after reset goes to freq0[9:4].
- Latency: register outputs update on the clk edge ending the accept cycle, so new values are visible the next cycle.
- noise_rst: high for exactly the cycle after any accepted write (latch or data) targeting the noise control register. Fires even if the value is unchanged.
- READY handshake:
  - On accept, ready = 0 from the next cycle for exactly BUSY_CYCLES cycles, then returns to 1.
  - Busy counter is sized to hold BUSY_CYCLES.
- tone_clk:
  - Free-running counter 0..PRESCALE-1, wraps to 0.
  - tone_clk = 1 in the cycle the counter equals PRESCALE-1.
  - Independent of writes and ready.
  - First pulse is PRESCALE cycles after reset release.
- Reset mid-busy: ready returns to 1 immediately and all registers return to reset values. A write pending in the same cycle as rst is discarded.

Test Plan:
- Reset then idle 64 cycles -> tone_clk pulses at cycles 16, 32, 48, 64 after release, one cycle wide; att0-3 = F, freq0-2 = 0, ready = 1.
- Write 8'h8E, wait ready, write 8'h0F -> freq0 = 10'h0FE; freq1 and freq2 unchanged; ready low 32 cycles after each accept.
- Write 8'hB5 -> att1 = 5; then data byte 8'h0A -> att1 = A; freq1 unchanged.
- Write 8'hE4 -> noise_ctrl = 3'b100 and a single-cycle noise_rst; then data byte 8'h03 -> noise_ctrl = 3'b011 and a second noise_rst pulse.
- Write 8'hC1, then toggle wr_n low during busy with 8'hCF -> freq2 = 10'h001; second byte ignored; ready timing not restarted.
- Write 8'hA7, assert rst at busy cycle 10 -> ready = 1 and att0..3 = F immediately; subsequent write 8'h9C after release is accepted and att0 = C.
